// File: rtl/note_pkg.sv
// Shared constants and types for the note decoder: period table, counter
// sizing, note codes and the window test used by the classifier.
package note_pkg;

    localparam int unsigned CNT_W     = 17;
    localparam int unsigned NUM_NOTES = 12;
    localparam int unsigned TOL_SHIFT = 6;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [3:0] {
        DO4       = 4'd0,
        DO_S4     = 4'd1,
        RE4       = 4'd2,
        RE_S4     = 4'd3,
        MI4       = 4'd4,
        FA4       = 4'd5,
        FA_S4     = 4'd6,
        SOL4      = 4'd7,
        SOL_S4    = 4'd8,
        LA4       = 4'd9,
        LA_S4     = 4'd10,
        SI4       = 4'd11,
        NOTE_NONE = 4'hF
    } note_e;

    typedef enum logic [1:0] {
        SILENCIO = 2'd0,
        PRIMER   = 2'd1,
        MIDIENDO = 2'd2
    } state_t;

    // Nominal periods in clk cycles at 25 MHz, index = note code.
    localparam logic [CNT_W-1:0] NOTE_PERIOD [NUM_NOTES] = '{
        17'd95555, 17'd90194, 17'd85133, 17'd80352,
        17'd75843, 17'd71586, 17'd67569, 17'd63776,
        17'd60197, 17'd56818, 17'd53630, 17'd50620
    };

    // True when per lies within nominal +/- (nominal >> TOL_SHIFT); bounds never exceed CNT_MAX.
    function automatic logic in_window(input logic [CNT_W-1:0] per,
                                       input logic [CNT_W-1:0] nominal);
        logic [CNT_W-1:0] tol;
        tol = nominal >> TOL_SHIFT;
        return (per >= (nominal - tol)) && (per <= (nominal + tol));
    endfunction

endpackage

// File: rtl/note_decoder_period_classifier.sv
// Maps a measured period onto a note code; lowest matching index wins,
// NOTE_NONE when no window contains the period.
module period_classifier
    import note_pkg::*;
(
    input  logic [CNT_W-1:0] per,
    output logic [3:0]       clase
);

    logic [NUM_NOTES-1:0] w_hit;

    for (genvar k = 0; k < NUM_NOTES; k++) begin : g_win
        assign w_hit[k] = in_window(per, NOTE_PERIOD[k]);
    end

    // Walk from the highest index down so the lowest hit is written last.
    always_comb begin
        clase = NOTE_NONE;
        for (int k = int'(NUM_NOTES) - 1; k >= 0; k--) begin
            if (w_hit[4'(k)]) begin
                clase = 4'(k);
            end
        end
    end

endmodule

// File: rtl/note_decoder.sv
// Measures the period of an asynchronous square wave and reports the matching
// 4th-octave note once two consecutive periods agree.
module note_decoder
    import note_pkg::*;
#(
    parameter int unsigned CLK_HZ = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       onda,
    output logic [3:0] nota,
    output logic       valida,
    output logic       fuera_rango
);

    // The period table is only meaningful at the nominal clock; never confirm otherwise.
    localparam logic TABLE_OK = (CLK_HZ == 32'd25000000);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_hist;
    logic             r_edge;
    state_t           r_state;
    logic [CNT_W-1:0] r_per_cnt;
    logic [3:0]       r_cand;
    logic [3:0]       r_nota;
    logic             r_valida;
    logic             r_fuera;

    logic             w_pulse;
    logic             w_sat;
    logic [3:0]       w_clase;

    assign w_pulse = r_sync2 & ~r_hist;
    assign w_sat   = (r_per_cnt == CNT_MAX);

    // Synchronizer, history flop and registered edge pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= onda;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_edge  <= w_pulse;
        end
    end

    period_classifier u_classifier (
        .per   (r_per_cnt),
        .clase (w_clase)
    );

    // Period counter, measurement FSM and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= SILENCIO;
            r_per_cnt <= '0;
            r_cand    <= NOTE_NONE;
            r_nota    <= 4'd0;
            r_valida  <= 1'b0;
            r_fuera   <= 1'b0;
        end else begin
            case (r_state)
                SILENCIO: begin
                    if (r_edge) begin
                        r_per_cnt <= CNT_W'(1);
                        r_state   <= PRIMER;
                    end
                end
                PRIMER, MIDIENDO: begin
                    // An edge takes priority over saturation; a saturated count classifies as none.
                    if (r_edge) begin
                        r_per_cnt <= CNT_W'(1);
                        r_cand    <= w_clase;
                        r_state   <= MIDIENDO;
                        if (w_clase == NOTE_NONE) begin
                            r_fuera  <= 1'b1;
                            r_valida <= 1'b0;
                        end else if ((r_state == MIDIENDO) && (w_clase == r_cand)) begin
                            r_nota   <= w_clase;
                            r_valida <= TABLE_OK;
                            r_fuera  <= 1'b0;
                        end
                    end else if (w_sat) begin
                        r_state  <= SILENCIO;
                        r_valida <= 1'b0;
                        r_fuera  <= 1'b0;
                    end else begin
                        r_per_cnt <= r_per_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= SILENCIO;
                end
            endcase
        end
    end

    assign nota        = r_nota;
    assign valida      = r_valida;
    assign fuera_rango = r_fuera;

endmodule

// File: tb/tb_note_decoder.sv
// Bench for note_decoder: classifier vector table and random sweep, then tone
// sequences checked edge by edge against a period-list model of the decoder.
module tb_note_decoder;

    logic        clk;
    logic        rst;
    logic        onda;
    logic [3:0]  nota;
    logic        valida;
    logic        fuera_rango;
    logic [16:0] tb_per;
    logic [3:0]  tb_clase;

    int n_err = 0;
    int n_chk = 0;

    int          m_edges;
    logic [3:0]  m_cand;
    logic [3:0]  m_nota;
    logic        m_val;
    logic        m_fr;
    int          m_pending;

    typedef struct {
        int         per;
        logic [3:0] clase;
    } cls_vec_t;

    cls_vec_t vecs[$];

    note_decoder #(.CLK_HZ(25000000)) dut (
        .clk         (clk),
        .rst         (rst),
        .onda        (onda),
        .nota        (nota),
        .valida      (valida),
        .fuera_rango (fuera_rango)
    );

    period_classifier u_cls (
        .per   (tb_per),
        .clase (tb_clase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end

    function automatic int np(input int k);
        case (k)
            0: return 95555;   1: return 90194;   2: return 85133;   3: return 80352;
            4: return 75843;   5: return 71586;   6: return 67569;   7: return 63776;
            8: return 60197;   9: return 56818;  10: return 53630;  11: return 50620;
            default: return 0;
        endcase
    endfunction

    // Note whose +/-1/64 window holds per, lowest first; 15 when none.
    function automatic int ref_class(input int per);
        int diff;
        for (int k = 0; k < 12; k++) begin
            diff = per - np(k);
            if (diff < 0) diff = -diff;
            if (diff <= np(k) / 64) return k;
        end
        return 15;
    endfunction

    function automatic void model_reset();
        m_edges   = 0;
        m_cand    = 4'hF;
        m_nota    = 4'd0;
        m_val     = 1'b0;
        m_fr      = 1'b0;
        m_pending = 0;
    endfunction

    // Effect of one rising edge given the period that just ended (m_pending).
    function automatic void model_edge();
        int c;
        if (m_edges == 0) begin
            m_edges = 1;
            return;
        end
        c = ref_class(m_pending);
        if (c == 15) begin
            m_fr  = 1'b1;
            m_val = 1'b0;
        end else if (m_edges >= 2 && 4'(c) == m_cand) begin
            m_nota = 4'(c);
            m_val  = 1'b1;
            m_fr   = 1'b0;
        end
        m_cand  = 4'(c);
        m_edges = 2;
    endfunction

    task automatic chk_out(input string name, input logic [3:0] e_nota,
                           input logic e_val, input logic e_fr);
        n_chk++;
        if (nota !== e_nota || valida !== e_val || fuera_rango !== e_fr) begin
            n_err++;
            $display("FAIL %s: got nota=%0d valida=%b fuera_rango=%b, want nota=%0d valida=%b fuera_rango=%b",
                     name, nota, valida, fuera_rango, e_nota, e_val, e_fr);
        end
    endtask

    task automatic chk_cls(input string name, input int per, input int expc);
        tb_per = 17'(per);
        #1;
        n_chk++;
        if (tb_clase !== 4'(expc)) begin
            n_err++;
            $display("FAIL %s: per=%0d got clase=%0d, want %0d", name, per, tb_clase, expc);
        end
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        onda = 1'b0;
        #2 rst = 1'b1;
        #1 chk_out("async_reset", 4'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One rising edge now, then p cycles until the next one; checks hold at +3 and update at +4.
    task automatic wave(input int p, input string tag);
        onda = 1'b1;
        repeat (3) @(negedge clk);
        chk_out({tag, "_hold"}, m_nota, m_val, m_fr);
        model_edge();
        @(negedge clk);
        chk_out({tag, "_upd"}, m_nota, m_val, m_fr);
        repeat (p / 2 - 4) @(negedge clk);
        onda = 1'b0;
        repeat (p - p / 2) @(negedge clk);
        m_pending = p;
    endtask

    initial begin
        int k;
        int span;
        int p;
        int k_prev;

        rst    = 1'b1;
        onda   = 1'b0;
        tb_per = '0;
        model_reset();

        vecs.push_back('{95555, 4'd0});   vecs.push_back('{97048, 4'd0});
        vecs.push_back('{97049, 4'hF});   vecs.push_back('{94062, 4'd0});
        vecs.push_back('{94061, 4'hF});   vecs.push_back('{50620, 4'd11});
        vecs.push_back('{51410, 4'd11});  vecs.push_back('{51411, 4'hF});
        vecs.push_back('{49830, 4'd11});  vecs.push_back('{49829, 4'hF});
        vecs.push_back('{56818, 4'd9});   vecs.push_back('{57705, 4'd9});
        vecs.push_back('{57706, 4'hF});   vecs.push_back('{53630, 4'd10});
        vecs.push_back('{54467, 4'd10});  vecs.push_back('{54468, 4'hF});
        vecs.push_back('{0, 4'hF});       vecs.push_back('{1, 4'hF});
        vecs.push_back('{131071, 4'hF});  vecs.push_back('{75843, 4'd4});
        for (int i = 0; i < vecs.size(); i++) begin
            chk_cls("cls_table", vecs[i].per, int'(vecs[i].clase));
        end

        repeat (300) begin
            if ($urandom_range(1, 0) == 1) begin
                k    = int'($urandom_range(11, 0));
                span = np(k) / 64 + 4;
                p    = np(k) + int'($urandom_range(32'(2 * span), 0)) - span;
            end else begin
                p = int'($urandom_range(131071, 0));
            end
            chk_cls("cls_random", p, ref_class(p));
        end

        // Reset mid-period, then 2 periods of Si4.
        do_reset();
        wave(50620, "rst_pre");
        repeat (20000) @(negedge clk);
        do_reset();
        wave(50620, "si_e1");
        chk_out("si_after_e1", 4'd0, 1'b0, 1'b0);
        wave(50620, "si_e2");
        chk_out("si_after_e2", 4'd0, 1'b0, 1'b0);
        wave(64, "si_e3");
        chk_out("si_after_e3", 4'd11, 1'b1, 1'b0);

        // La4 confirmation with exact latency, then alternation with La#4.
        do_reset();
        wave(56818, "la_e1");
        wave(56818, "la_e2");
        wave(56818, "la_e3");
        chk_out("la_confirm", 4'd9, 1'b1, 1'b0);
        wave(53630, "alt");
        wave(56818, "alt");
        wave(53630, "alt");
        wave(56818, "alt");
        wave(64, "alt");
        chk_out("alt_hold", 4'd9, 1'b1, 1'b0);

        // Tolerance edge of Do4: +1492 still matches, +1494 does not.
        do_reset();
        wave(95555, "win");
        wave(95555 + 1492, "win");
        wave(95555 + 1494, "win");
        chk_out("win_inside", 4'd0, 1'b1, 1'b0);
        wave(64, "win");
        chk_out("win_outside", 4'd0, 1'b0, 1'b1);

        // Sweep all notes in order without leaving measurement.
        do_reset();
        wave(np(0), "sweep");
        wave(np(0), "sweep");
        for (int n = 0; n < 12; n++) begin
            wave((n < 11) ? np(n + 1) : 64, "sweep");
            chk_out("sweep_note", 4'(n), 1'b1, 1'b0);
            if (n < 11) wave(np(n + 1), "sweep");
        end

        // Do4 then silence: timeout exactly 131071 cycles after the last edge.
        do_reset();
        wave(95555, "to");
        wave(95555, "to");
        wave(95555, "to");
        chk_out("to_confirm", 4'd0, 1'b1, 1'b0);
        repeat (131074 - 95555) @(negedge clk);
        chk_out("to_before", 4'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("to_after", 4'd0, 1'b0, 1'b0);

        // Random periods near the table, often repeating the previous note.
        do_reset();
        k_prev = int'($urandom_range(11, 0));
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(1, 0) == 0) k_prev = int'($urandom_range(11, 0));
            span = np(k_prev) / 64 + 200;
            p    = np(k_prev) + int'($urandom_range(32'(2 * span), 0)) - span;
            wave(p, "rnd");
        end
        wave(64, "rnd");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/note_decoder.md
NOTE_DECODER -- requirements
Module: note_decoder

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000, system clock frequency; the period table is valid only for this value.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port onda  input  1  square-wave tone input, asynchronous to clk (one synthesizer note output or a merged line).
REQ-005 SHALL have port nota  output  4  decoded note index, 0=Do4, 1=Do#4, 2=Re4, 3=Re#4, 4=Mi4, 5=Fa4, 6=Fa#4, 7=Sol4, 8=Sol#4, 9=La4, 10=La#4, 11=Si4.
REQ-006 SHALL have port valida  output  1  high while nota holds a confirmed note.
REQ-007 SHALL have port fuera_rango  output  1  high when the last measured period matched no note.

Function
REQ-008 SHALL pass onda through a 2-flop synchronizer plus one history flop; a rising edge is sync2=1 and hist=0 (one-cycle pulse).
REQ-009 SHALL count clk cycles between consecutive rising edges in a 17-bit counter `per_cnt`, saturating at 131071.
REQ-010 SHALL have FSM states SILENCIO, PRIMER and MIDIENDO; the reset state is SILENCIO.
REQ-011 SILENCIO: on an edge pulse, SHALL load per_cnt=1 and go to PRIMER.
REQ-012 PRIMER: on an edge pulse, SHALL classify the period, store the result as `candidato`, reload per_cnt=1 and go to MIDIENDO; the outputs do not change.
REQ-013 MIDIENDO: on an edge pulse, SHALL classify the period, reload per_cnt=1 and stay in MIDIENDO.
REQ-014 In MIDIENDO, if the class equals candidato and is a note, SHALL set nota=class and valida=1 and clear fuera_rango, all on the clock edge that samples the pulse.
REQ-015 If the class differs from candidato, SHALL replace candidato and leave nota and valida unchanged.
REQ-016 If the class is "none" in PRIMER or MIDIENDO, SHALL set fuera_rango=1 and valida=0 and keep nota.
REQ-017 Classification SHALL match note k when |per - NOTE_PERIOD[k]| <= NOTE_PERIOD[k]>>6 (about ±1.56%).
REQ-018 The matching windows SHALL be disjoint; if several notes match, the lowest index wins, and if none match the class is "none".
REQ-019 NOTE_PERIOD SHALL be {95555, 90194, 85133, 80352, 75843, 71586, 67569, 63776, 60197, 56818, 53630, 50620}.
REQ-020 When per_cnt saturates in PRIMER or MIDIENDO, SHALL go to SILENCIO, clear valida and fuera_rango, and keep nota.
REQ-021 If an edge pulse and saturation occur in the same cycle, the edge SHALL win and the period is classified as 131071 (class "none").
REQ-022 Latency SHALL be 4 clk rising edges from a raw onda rising edge (setup-compliant) to the output update.
REQ-023 A note SHALL need at least 3 rising edges (2 matching periods) after SILENCIO to become valida.

Reset
REQ-024 While rst=1, SHALL force state=SILENCIO, per_cnt=0, candidato="none", nota=0, valida=0, fuera_rango=0 and all synchronizer flops to 0, regardless of clk.
REQ-025 Reset asserted mid-measurement SHALL discard the partial period; after release, decoding restarts from SILENCIO.

Structure
REQ-026 A shared package note_pkg SHALL hold NOTE_PERIOD, TOL_SHIFT=6, CNT_W=17, CNT_MAX, the 4-bit note indices and the "none" code (4'hF).
REQ-027 One combinational sub-module period_classifier SHALL hold the 12 window comparators and the priority encoder (input per[16:0], output clase[3:0]).
REQ-028 The sequential logic (synchronizer, counter, FSM, output registers) SHALL stay in note_decoder.

Verification
REQ-029 Drive reset mid-period; release; drive 2 periods of 50620 -> valida=0 throughout, then nota=11 and valida=1 only after the 3rd edge following release.
REQ-030 Drive 3 periods of 56818 cycles -> nota=9 and valida=1 exactly 4 cycles after the 3rd onda rising edge; fuera_rango=0.
REQ-031 Drive 95555 then 95555 + 1492 (edge of window) -> nota=0 and valida=1; repeat with +1494 -> fuera_rango=1 and valida=0.
REQ-032 Sweep all 12 NOTE_PERIOD values, 3 periods each -> nota equals the index 0..11 in order, with valida=1 after each confirmation.
REQ-033 Confirm La4, then alternate periods 56818/53630 -> nota stays 9; candidato toggles, no new confirmation.
REQ-034 Confirm Do4, then hold onda low -> 131071 cycles after the last edge, valida=0, fuera_rango=0 and nota=0 retained.
